// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and types for the VGA sync generator/decoder pair.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_PULSE  = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_PULSE  = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  // Active window measured from the sync falling edge (pulse + back porch).
  localparam int unsigned H_ACT_START = H_PULSE + H_BACK;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = V_PULSE + V_BACK;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE - 1;

  // Position / period counters are 10 bits and saturate.
  localparam int unsigned      CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_COUNTING = 2'd1,
    LK_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_axis.sv
// One timing axis: counts enables since the last sync mark, measures the period,
// and once armed flags a period mismatch or a missing mark (timeout).
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter logic [CNT_W-1:0] TOTAL = CNT_W'(H_TOTAL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             mark,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] meas,
  output logic             err,
  output logic             good
);

  logic armed;
  logic timeout;
  logic mismatch;

  // Check decode: a timeout is the enable that would step past TOTAL without a mark.
  always_comb begin
    timeout  = armed & en & ~mark & (cnt == TOTAL);
    mismatch = armed & mark & (cnt != TOTAL);
    good     = armed & mark & (cnt == TOTAL);
    err      = timeout | mismatch;
  end

  // Edge-reset counter; the enable coincident with the mark is counted as the first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (mark) begin
      cnt <= en ? CNT_ONE : '0;
    end else if (en && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Arm on any mark, disarm after a timeout so a stall reports only once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (mark) begin
      armed <= 1'b1;
    end else if (timeout) begin
      armed <= 1'b0;
    end
  end

  // Period measurement, only taken on armed marks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meas <= '0;
    end else if (armed && mark) begin
      meas <= cnt;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive side: recovers pixel coordinates from hsync/vsync, checks timing
// against nominal, tracks lock and emits a registered qualified pixel stream.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_PULSE     = vga_timing_pkg::H_PULSE,
  parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
  parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_PULSE     = vga_timing_pkg::V_PULSE,
  parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] color_in,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [7:0] pixel_data,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas
);

  localparam logic [CNT_W-1:0] HT = CNT_W'(H_ACTIVE + H_FRONT + H_PULSE + H_BACK);
  localparam logic [CNT_W-1:0] HS = CNT_W'(H_PULSE + H_BACK);
  localparam logic [CNT_W-1:0] HE = CNT_W'(H_PULSE + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VT = CNT_W'(V_ACTIVE + V_FRONT + V_PULSE + V_BACK);
  localparam logic [CNT_W-1:0] VS = CNT_W'(V_PULSE + V_BACK);
  localparam logic [CNT_W-1:0] VE = CNT_W'(V_PULSE + V_BACK + V_ACTIVE - 1);

  localparam int unsigned      LCW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_FRAMES);

  logic             hs_d, vs_d;
  logic             hfall, vfall;
  logic [CNT_W-1:0] h_cnt, h_pos;
  logic [CNT_W-1:0] v_cnt, v_line;
  logic             vpend;
  logic             h_err, v_err, any_err;
  logic             h_good, v_good, good_frame;
  logic             frame_bad;
  logic             active, valid_d;
  logic             unused_axis;

  lock_state_t      state_q, state_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

  // Sync falling-edge detect against the previous sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_d <= hsync_in;
      vs_d <= vsync_in;
    end
  end

  // Edge decode and horizontal position of the current sample.
  always_comb begin
    hfall       = hs_d & ~hsync_in;
    vfall       = vs_d & ~vsync_in;
    h_pos       = hfall ? '0 : h_cnt;
    any_err     = h_err | v_err;
    good_frame  = v_good & ~frame_bad & ~h_err;
    unused_axis = ^{v_cnt, h_good};
  end

  vga_sync_axis #(.TOTAL(HT)) u_h_axis (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .mark  (hfall),
    .cnt   (h_cnt),
    .meas  (h_total_meas),
    .err   (h_err),
    .good  (h_good)
  );

  vga_sync_axis #(.TOTAL(VT)) u_v_axis (
    .clock (clock),
    .reset (reset),
    .en    (hfall),
    .mark  (vfall),
    .cnt   (v_cnt),
    .meas  (v_total_meas),
    .err   (v_err),
    .good  (v_good)
  );

  // Line index: a vfall seen anywhere in a line makes the next hfall start line 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vpend  <= 1'b0;
      v_line <= '0;
    end else if (hfall) begin
      vpend  <= 1'b0;
      if (vpend || vfall) begin
        v_line <= '0;
      end else if (v_line != CNT_MAX) begin
        v_line <= v_line + CNT_ONE;
      end
    end else if (vfall) begin
      vpend <= 1'b1;
    end
  end

  // Any horizontal error since the last vfall disqualifies that frame from counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_bad <= 1'b0;
    end else begin
      frame_bad <= vfall ? 1'b0 : (frame_bad | h_err);
    end
  end

  // Lock state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LK_UNLOCKED;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock next-state: errors drop lock, good armed frames count up to LOCK_FRAMES.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (any_err) begin
      state_d    = LK_UNLOCKED;
      lock_cnt_d = '0;
    end else if (good_frame) begin
      if (lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
      state_d = (lock_cnt_d == LOCK_MAX) ? LK_LOCKED : LK_COUNTING;
    end
    locked = (state_q == LK_LOCKED);
  end

  // Active-window qualification; an error this cycle suppresses the pixel together with lock.
  always_comb begin
    active  = (h_pos >= HS) && (h_pos <= HE) && (v_line >= VS) && (v_line <= VE);
    valid_d = active & locked & ~any_err;
  end

  // Registered pixel stream and error pulse, one cycle after the sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_valid  <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      pixel_data   <= '0;
      frame_start  <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      pixel_valid  <= valid_d;
      pixel_x      <= valid_d ? (h_pos - HS) : '0;
      pixel_y      <= valid_d ? (v_line - VS) : '0;
      pixel_data   <= valid_d ? color_in : '0;
      frame_start  <= valid_d && (h_pos == HS) && (v_line == VS);
      timing_error <= any_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster so whole frames stay short.
module tb_vga_sync_decoder;

  localparam int T_HA = 16, T_HF = 2, T_HP = 4, T_HB = 3;
  localparam int T_VA = 6,  T_VF = 1, T_VP = 2, T_VB = 2;
  localparam int T_HT = T_HA + T_HF + T_HP + T_HB;  // 25 clocks per line
  localparam int T_VT = T_VA + T_VF + T_VP + T_VB;  // 11 lines per frame
  localparam int T_HS = T_HP + T_HB;                // first active clock 7
  localparam int T_VS = T_VP + T_VB;                // first active line 4
  localparam int FULL = T_HA * T_VA;                // 96 pixels per frame

  logic       clock;
  logic       reset;
  logic       hsync_in, vsync_in;
  logic [7:0] color_in;
  logic       pixel_valid;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] pixel_data;
  logic       frame_start, locked, timing_error;
  logic [9:0] h_total_meas, v_total_meas;

  vga_sync_decoder #(
    .H_ACTIVE(T_HA), .H_FRONT(T_HF), .H_PULSE(T_HP), .H_BACK(T_HB),
    .V_ACTIVE(T_VA), .V_FRONT(T_VF), .V_PULSE(T_VP), .V_BACK(T_VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .color_in     (color_in),
    .pixel_valid  (pixel_valid),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_data   (pixel_data),
    .frame_start  (frame_start),
    .locked       (locked),
    .timing_error (timing_error),
    .h_total_meas (h_total_meas),
    .v_total_meas (v_total_meas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int lines;       // lines in this frame
    int short_line;  // line driven one clock short, -1 for none
    int lock_start;  // locked right after the frame's vfall cycle
    int errs;        // timing_error pulses seen during the frame
    int valids;      // pixel_valid cycles during the frame
    int err_h;       // h_total_meas at first error, -1 to skip
    int err_v;       // v_total_meas at first error, -1 to skip
    int lock_end;    // locked at end of frame
  } vec_t;

  vec_t vecs[11];

  int checks, errors;
  int n_err, n_valid, n_fs, fs_bad, data_bad;
  int first_x, first_y, first_line, last_x, last_y;
  int err_h, err_v, cur_line, lock0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_err = 0; n_valid = 0; n_fs = 0; fs_bad = 0; data_bad = 0;
    first_x = -1; first_y = -1; first_line = -1; last_x = -1; last_y = -1;
    err_h = -1; err_v = -1; lock0 = -1;
  endtask

  task automatic sample();
    if (timing_error) begin
      if (n_err == 0) begin
        err_h = int'(h_total_meas);
        err_v = int'(v_total_meas);
      end
      n_err++;
    end
    if (pixel_valid) begin
      if (n_valid == 0) begin
        first_x    = int'(pixel_x);
        first_y    = int'(pixel_y);
        first_line = cur_line;
      end
      n_valid++;
      last_x = int'(pixel_x);
      last_y = int'(pixel_y);
      if (pixel_data != {pixel_y[3:0], pixel_x[3:0]}) data_bad++;
    end
    if (frame_start) begin
      n_fs++;
      if (!(pixel_valid && pixel_x == 10'd0 && pixel_y == 10'd0)) fs_bad++;
    end
  endtask

  task automatic drive_cycle(input logic hs, input logic vs, input logic [7:0] c);
    hsync_in = hs;
    vsync_in = vs;
    color_in = c;
    @(posedge clock);
    #1;
    sample();
  endtask

  task automatic drive_pos(input int l, input int h);
    logic [3:0] yv, xv;
    yv = 4'(l - T_VS);
    xv = 4'(h - T_HS);
    drive_cycle((h < T_HP) ? 1'b0 : 1'b1, (l < T_VP) ? 1'b0 : 1'b1, {yv, xv});
  endtask

  task automatic send_line(input int l, input int len);
    cur_line = l;
    for (int h = 0; h < len; h++) begin
      drive_pos(l, h);
      if (l == 0 && h == 0) lock0 = int'(locked);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    clear_stats();
    for (int l = 0; l < v.lines; l++) begin
      send_line(l, (l == v.short_line) ? T_HT - 1 : T_HT);
    end
    check($sformatf("f%0d lock_after_vfall", idx), lock0, v.lock_start);
    check($sformatf("f%0d error_pulses", idx), n_err, v.errs);
    check($sformatf("f%0d valid_count", idx), n_valid, v.valids);
    check($sformatf("f%0d locked_at_end", idx), int'(locked), v.lock_end);
    check($sformatf("f%0d stray_frame_start", idx), fs_bad, 0);
    if (v.err_h >= 0) check($sformatf("f%0d h_meas_at_error", idx), err_h, v.err_h);
    if (v.err_v >= 0) check($sformatf("f%0d v_meas_at_error", idx), err_v, v.err_v);
    if (v.valids == FULL) begin
      check($sformatf("f%0d first_x", idx), first_x, 0);
      check($sformatf("f%0d first_y", idx), first_y, 0);
      check($sformatf("f%0d first_line", idx), first_line, T_VS);
      check($sformatf("f%0d last_x", idx), last_x, T_HA - 1);
      check($sformatf("f%0d last_y", idx), last_y, T_VA - 1);
      check($sformatf("f%0d frame_start_count", idx), n_fs, 1);
      check($sformatf("f%0d data_errors", idx), data_bad, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pixel_valid"}, int'(pixel_valid), 0);
    check({tag, " pixel_x"}, int'(pixel_x), 0);
    check({tag, " pixel_y"}, int'(pixel_y), 0);
    check({tag, " pixel_data"}, int'(pixel_data), 0);
    check({tag, " flags"}, int'({frame_start, locked, timing_error}), 0);
    check({tag, " h_total_meas"}, int'(h_total_meas), 0);
    check({tag, " v_total_meas"}, int'(v_total_meas), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur_line = 0;
    clear_stats();
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    color_in = 8'h00;

    //           lines       short lk0 errs valids err_h    err_v    lk_end
    vecs[0]  = '{T_VT,     -1,     0, 0, 0,     -1,      -1,      0};  // arms only
    vecs[1]  = '{T_VT,     -1,     0, 0, 0,     -1,      -1,      0};  // lock_cnt 1
    vecs[2]  = '{T_VT,     -1,     1, 0, FULL,  -1,      -1,      1};  // locks
    vecs[3]  = '{T_VT,     6,      1, 1, 3*T_HA, T_HT-1, -1,      0};  // short line
    vecs[4]  = '{T_VT,     -1,     0, 0, 0,     -1,      -1,      0};  // bad frame ends
    vecs[5]  = '{T_VT,     -1,     0, 0, 0,     -1,      -1,      0};
    vecs[6]  = '{T_VT,     -1,     1, 0, FULL,  -1,      -1,      1};  // relocked
    vecs[7]  = '{T_VT-1,   -1,     1, 0, FULL,  -1,      -1,      1};  // short frame
    vecs[8]  = '{T_VT,     -1,     0, 1, 0,     -1,      T_VT-1,  0};  // caught at vfall
    vecs[9]  = '{T_VT,     -1,     0, 0, 0,     -1,      -1,      0};
    vecs[10] = '{T_VT,     -1,     1, 0, FULL,  -1,      -1,      1};

    @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b1, 8'h00);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // hsync stuck high: one timeout, then silence while the counter saturates.
    clear_stats();
    repeat (1200) drive_cycle(1'b1, 1'b1, 8'h00);
    check("stall error_pulses", n_err, 1);
    check("stall valid_count", n_valid, 0);
    check("stall locked", int'(locked), 0);
    check("stall h_total_meas", int'(h_total_meas), T_HT);

    // Resume: first hfall re-arms silently, frame with the stall is not counted.
    run_vec('{T_VT, -1, 0, 0, 0, -1, -1, 0}, 11);
    run_vec('{T_VT, -1, 0, 0, 0, -1, -1, 0}, 12);

    // Relock, then assert reset between clock edges in the middle of an active line.
    clear_stats();
    send_line(0, T_HT);
    check("relock after stall", lock0, 1);
    for (int l = 1; l < 6; l++) send_line(l, T_HT);
    cur_line = 6;
    for (int h = 0; h < 12; h++) drive_pos(6, h);
    check("midline pixel_valid", int'(pixel_valid), 1);
    check("midline pixel_x", int'(pixel_x), 4);
    check("midline pixel_y", int'(pixel_y), 2);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b1, 8'h00);

    run_vec('{T_VT, -1, 0, 0, 0,    -1, -1, 0}, 13);
    run_vec('{T_VT, -1, 0, 0, 0,    -1, -1, 0}, 14);
    run_vec('{T_VT, -1, 1, 0, FULL, -1, -1, 1}, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
